// File: rtl/dstack_rot.sv
// Parametrised shift-register data stack with occupancy count, sticky flags and replace-top.
// Optional rotate-to-top datapath and rot_val mux are built only when DSTACK_ROT_ROTATE_EN is defined.
module dstack_rot #(
  parameter int WIDTH     = 32,
  parameter int DEPTH_MAG = 7,
  parameter int ROT_MAG   = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           movement,
  input  logic [WIDTH-1:0]     next_top,
  input  logic                 rotate,
  input  logic [ROT_MAG-1:0]   rot_addr,
  input  logic                 clear_flags,
  output logic [WIDTH-1:0]     top,
  output logic [WIDTH-1:0]     second,
  output logic [WIDTH-1:0]     third,
  output logic [WIDTH-1:0]     rot_val,
  output logic [DEPTH_MAG:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 1 << DEPTH_MAG;
  localparam logic [1:0] MV_PUSH = 2'b01;
  localparam logic [1:0] MV_POP  = 2'b10;
  localparam logic [1:0] MV_REPL = 2'b11;
  localparam logic [DEPTH_MAG:0] C_FULL = (DEPTH_MAG+1)'(DEPTH);
  localparam logic [DEPTH_MAG:0] C_ONE  = (DEPTH_MAG+1)'(1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [DEPTH_MAG:0] r_count;
  logic               r_ovf;
  logic               r_udf;

  logic               w_full;
  logic               w_empty;
  logic               w_rot_go;
  logic               w_rot_bad;
  logic               w_set_ovf;
  logic               w_set_udf;
  logic [DEPTH_MAG:0] w_k;

  assign w_k     = (DEPTH_MAG+1)'(rot_addr);
  assign w_full  = (r_count == C_FULL);
  assign w_empty = (r_count == '0);

`ifdef DSTACK_ROT_ROTATE_EN
  // k = 0 is a plain no-op and never flags; only k >= count with k > 0 is an underflow.
  assign w_rot_go  = rotate && (movement == 2'b00) && (w_k != '0);
  assign w_rot_bad = w_rot_go && (w_k >= r_count);
  assign rot_val   = r_mem[w_k[DEPTH_MAG-1:0]];
`else
  logic w_unused_rot;
  assign w_unused_rot = rotate;
  assign w_rot_go     = 1'b0;
  assign w_rot_bad    = 1'b0;
  assign rot_val      = '0;
`endif

  assign w_set_ovf = (movement == MV_PUSH) && w_full;
  assign w_set_udf = ((movement == MV_POP) && w_empty) || w_rot_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      case (movement)
        MV_PUSH: begin
          r_mem[0] <= next_top;
          for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
          if (!w_full) r_count <= r_count + C_ONE;
        end
        MV_POP: begin
          for (int i = 0; i < DEPTH-1; i++) r_mem[i] <= r_mem[i+1];
          r_mem[DEPTH-1] <= '0;
          if (!w_empty) r_count <= r_count - C_ONE;
        end
        MV_REPL: begin
          r_mem[0] <= next_top;
          if (w_empty) r_count <= C_ONE;
        end
        default: begin
          if (w_rot_go && !w_rot_bad) begin
            r_mem[0] <= r_mem[w_k[DEPTH_MAG-1:0]];
            for (int i = 1; i < DEPTH; i++)
              if (i <= int'(w_k)) r_mem[i] <= r_mem[i-1];
          end
        end
      endcase
      // Setting events override a same-cycle clear.
      r_ovf <= (r_ovf & ~clear_flags) | w_set_ovf;
      r_udf <= (r_udf & ~clear_flags) | w_set_udf;
    end
  end

  assign top       = r_mem[0];
  assign second    = r_mem[1];
  assign third     = r_mem[2];
  assign count     = r_count;
  assign overflow  = r_ovf;
  assign underflow = r_udf;

endmodule

// File: tb/tb_dstack_rot.sv
// Self-checking bench for dstack_rot (DEPTH 8) against a queue-based reference model.
// Rotate checks are compiled in only with DSTACK_ROT_ROTATE_EN defined.
module tb_dstack_rot;
  localparam int W  = 16;
  localparam int DM = 3;
  localparam int RM = 3;
  localparam int D  = 1 << DM;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    movement;
  logic [W-1:0]  next_top;
  logic          rotate;
  logic [RM-1:0] rot_addr;
  logic          clear_flags;
  logic [W-1:0]  top, second, third, rot_val;
  logic [DM:0]   count;
  logic          overflow, underflow;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] q[$];
  int           m_cnt;
  logic         m_ovf, m_udf;

  dstack_rot #(.WIDTH(W), .DEPTH_MAG(DM), .ROT_MAG(RM)) dut (
    .clk(clk), .reset(reset), .movement(movement), .next_top(next_top),
    .rotate(rotate), .rot_addr(rot_addr), .clear_flags(clear_flags),
    .top(top), .second(second), .third(third), .rot_val(rot_val),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < D; i++) q.push_back('0);
    m_cnt = 0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endfunction

  function automatic void model_apply(input logic [1:0] mv, input logic [W-1:0] nt,
                                      input logic rt, input int k, input logic cf);
    logic so, su;
    logic [W-1:0] x;
    so = 1'b0;
    su = 1'b0;
    case (mv)
      2'b01: begin
        q.push_front(nt);
        void'(q.pop_back());
        if (m_cnt < D) m_cnt++; else so = 1'b1;
      end
      2'b10: begin
        void'(q.pop_front());
        q.push_back('0);
        if (m_cnt > 0) m_cnt--; else su = 1'b1;
      end
      2'b11: begin
        q[0] = nt;
        if (m_cnt == 0) m_cnt = 1;
      end
      default: begin
`ifdef DSTACK_ROT_ROTATE_EN
        if (rt && k != 0) begin
          if (k >= m_cnt) su = 1'b1;
          else begin
            x = q[k];
            q.delete(k);
            q.push_front(x);
          end
        end
`endif
      end
    endcase
    if (cf) begin m_ovf = 1'b0; m_udf = 1'b0; end
    if (so) m_ovf = 1'b1;
    if (su) m_udf = 1'b1;
  endfunction

  task automatic check_all(input string tag);
    logic [W-1:0] erv;
`ifdef DSTACK_ROT_ROTATE_EN
    erv = q[int'(rot_addr)];
`else
    erv = '0;
`endif
    chk({tag, ".top"},    32'(top),       32'(q[0]));
    chk({tag, ".second"}, 32'(second),    32'(q[1]));
    chk({tag, ".third"},  32'(third),     32'(q[2]));
    chk({tag, ".count"},  32'(count),     32'(m_cnt));
    chk({tag, ".ovf"},    32'(overflow),  32'(m_ovf));
    chk({tag, ".udf"},    32'(underflow), 32'(m_udf));
    chk({tag, ".rotval"}, 32'(rot_val),   32'(erv));
  endtask

  task automatic step(input string tag, input logic [1:0] mv, input logic [W-1:0] nt,
                      input logic rt, input logic [RM-1:0] ra, input logic cf);
    @(negedge clk);
    movement = mv; next_top = nt; rotate = rt; rot_addr = ra; clear_flags = cf;
    @(posedge clk);
    model_apply(mv, nt, rt, int'(ra), cf);
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b0; movement = 2'b00; next_top = '0; rotate = 1'b0;
    rot_addr = '0; clear_flags = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) reset = 1'b1;

    // basic push/pop
    step("push11", 2'b01, 16'h11, 1'b0, 3'd0, 1'b0);
    step("push22", 2'b01, 16'h22, 1'b0, 3'd0, 1'b0);
    step("push33", 2'b01, 16'h33, 1'b0, 3'd0, 1'b0);
    chk("plan.top33", 32'(top), 32'h33);
    chk("plan.third11", 32'(third), 32'h11);
    step("pop", 2'b10, 16'h0, 1'b0, 3'd0, 1'b0);
    chk("plan.pop_top", 32'(top), 32'h22);
    chk("plan.pop_cnt", 32'(count), 32'd2);

    // fill past full, back-to-back overflow pushes
    for (int i = 0; i < D + 2; i++) step("fill", 2'b01, 16'(i + 1), 1'b0, 3'd1, 1'b0);
    chk("plan.full_cnt", 32'(count), 32'(D));
    chk("plan.ovf", 32'(overflow), 32'd1);
    step("clr_ovf", 2'b00, 16'h0, 1'b0, 3'd0, 1'b1);

    // drain past empty, clear racing with underflow
    for (int i = 0; i < D + 1; i++) step("drain", 2'b10, 16'h0, 1'b0, 3'd0, 1'b0);
    step("pop_clr", 2'b10, 16'h0, 1'b0, 3'd0, 1'b1);
    chk("plan.udf_set_wins", 32'(underflow), 32'd1);
    step("clr_only", 2'b00, 16'h0, 1'b0, 3'd0, 1'b1);
    chk("plan.udf_clear", 32'(underflow), 32'd0);

    // rotate cases (A,B,C,D with D on top)
    step("pA", 2'b01, 16'hA, 1'b0, 3'd0, 1'b0);
    step("pB", 2'b01, 16'hB, 1'b0, 3'd0, 1'b0);
    step("pC", 2'b01, 16'hC, 1'b0, 3'd0, 1'b0);
    step("pD", 2'b01, 16'hD, 1'b0, 3'd0, 1'b0);
    step("rot2", 2'b00, 16'h0, 1'b1, 3'd2, 1'b0);
    step("rot5", 2'b00, 16'h0, 1'b1, 3'd5, 1'b0);
    step("rot0", 2'b00, 16'h0, 1'b1, 3'd0, 1'b0);
    step("rot3", 2'b00, 16'h0, 1'b1, 3'd3, 1'b1);
`ifdef DSTACK_ROT_ROTATE_EN
    chk("plan.rot3_top", 32'(top), 32'hA);
`else
    chk("plan.norot_top", 32'(top), 32'hD);
`endif
    step("rot_push", 2'b01, 16'hE, 1'b1, 3'd2, 1'b0);
    chk("plan.rot_push_top", 32'(top), 32'hE);

    // replace on empty
    for (int i = 0; i < 6; i++) step("empty", 2'b10, 16'h0, 1'b0, 3'd0, 1'b1);
    step("repl_empty", 2'b11, 16'h99, 1'b0, 3'd0, 1'b0);
    chk("plan.repl_cnt", 32'(count), 32'd1);
    step("repl", 2'b11, 16'h77, 1'b0, 3'd0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [1:0] mv;
      mv = 2'($urandom_range(0, 3));
      step("rand", mv, 16'($urandom), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
    end

    // asynchronous reset mid-burst
    for (int i = 0; i < 3; i++) step("burst", 2'b01, 16'h100 + 16'(i), 1'b0, 3'd1, 1'b0);
    @(negedge clk);
    movement = 2'b01; next_top = 16'h5A5A;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    movement = 2'b00;
    reset = 1'b1;
    step("post_rst", 2'b01, 16'h42, 1'b0, 3'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
